// File: rtl/grant_burst_ctrl_pkg.sv
// Shared definitions for the grant-driven burst controller: state encoding,
// default widths and the beat-counter sizing helper.
package grant_burst_ctrl_pkg;

    localparam int unsigned DEFAULT_N = 4;
    localparam int unsigned DEFAULT_W = 8;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StXfer    = 2'd1,
        StRelease = 2'd2
    } state_e;

    // One extra bit over clog2 keeps the MAX_BURST=1 case at a legal 1-bit width.
    function automatic int unsigned count_width(input int unsigned max_burst);
        return $clog2(max_burst) + 1;
    endfunction

endpackage

// File: rtl/onehot_lsb_pick.sv
// Isolates the lowest set bit of a vector and flags when more than one bit is set.
module onehot_lsb_pick #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] vec,
    output logic [N-1:0] lsb,
    output logic         multi
);

    // Two's-complement trick: vec & -vec keeps only the lowest set bit.
    assign lsb   = vec & (~vec + N'(1));
    assign multi = |(vec & ~lsb);

endmodule

// File: rtl/grant_burst_ctrl.sv
// Locks the shared output channel to the arbiter's granted requester for one burst
// and routes that requester's beats through a valid/ready handshake.
module grant_burst_ctrl
    import grant_burst_ctrl_pkg::*;
#(
    parameter int unsigned N         = DEFAULT_N,
    parameter int unsigned W         = DEFAULT_W,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   grant,
    input  logic [N-1:0]   in_valid,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_last,
    output logic [N-1:0]   in_ready,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic           out_last,
    input  logic           out_ready,
    output logic [N-1:0]   owner,
    output logic           busy,
    output logic           burst_release,
    output logic           grant_err
);

    localparam int unsigned CW = count_width(MAX_BURST);

    state_e         state_q, state_d;
    logic [N-1:0]   owner_q, owner_d;
    logic [CW-1:0]  count_q, count_d;
    logic           err_q, err_d;

    logic [N-1:0]   grant_lsb;
    logic           grant_multi;

    logic           sel_valid;
    logic [W-1:0]   sel_data;
    logic           sel_last;
    logic           xfer;
    logic           at_limit;
    logic           beat;
    logic           burst_end;

    onehot_lsb_pick #(
        .N (N)
    ) u_pick (
        .vec   (grant),
        .lsb   (grant_lsb),
        .multi (grant_multi)
    );

    // Owner is one-hot, so OR-ing the selected lanes yields a clean mux.
    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        sel_last  = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            if (owner_q[i]) begin
                sel_valid = sel_valid | in_valid[i];
                sel_data  = sel_data | in_data[i*W +: W];
                sel_last  = sel_last | in_last[i];
            end
        end
    end

    assign xfer      = (state_q == StXfer);
    assign at_limit  = (count_q == CW'(MAX_BURST - 1));
    assign out_valid = xfer & sel_valid;
    assign out_data  = xfer ? sel_data : '0;
    assign out_last  = out_valid & (sel_last | at_limit);
    assign in_ready  = owner_q & {N{xfer & out_ready}};
    assign beat      = out_valid & out_ready;
    assign burst_end = beat & (sel_last | at_limit);

    assign owner         = owner_q;
    assign busy          = (state_q != StIdle);
    assign burst_release = (state_q == StRelease);
    assign grant_err     = err_q;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        count_d = count_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (|grant) begin
                    owner_d = grant_lsb;
                    count_d = '0;
                    err_d   = err_q | grant_multi;
                    state_d = StXfer;
                end
            end
            StXfer: begin
                if (beat) begin
                    count_d = count_q + CW'(1);
                    if (burst_end) begin
                        state_d = StRelease;
                    end
                end
            end
            StRelease: begin
                owner_d = '0;
                count_d = '0;
                state_d = StIdle;
            end
            default: begin
                owner_d = '0;
                count_d = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            owner_q <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_grant_burst_ctrl.sv
// Directed scoreboard bench for grant_burst_ctrl: stimulus pushes expected beats,
// a negedge monitor pops and compares every accepted beat.
module tb_grant_burst_ctrl;

    localparam int unsigned N = 4;
    localparam int unsigned W = 8;

    logic           clk;
    logic           rst;
    logic [N-1:0]   grant;
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_last;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic           out_last;
    logic           out_ready;
    logic [N-1:0]   owner;
    logic           busy;
    logic           burst_release;
    logic           grant_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W:0] exp_q[$];

    grant_burst_ctrl #(
        .N         (N),
        .W         (W),
        .MAX_BURST (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .grant         (grant),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_last       (in_last),
        .in_ready      (in_ready),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_last      (out_last),
        .out_ready     (out_ready),
        .owner         (owner),
        .busy          (busy),
        .burst_release (burst_release),
        .grant_err     (grant_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int r, input logic [7:0] d, input logic l);
        in_valid[r]        = 1'b1;
        in_data[r*8 +: 8]  = d;
        in_last[r]         = l;
    endtask

    task automatic clear_inputs();
        grant     = '0;
        in_valid  = '0;
        in_data   = '0;
        in_last   = '0;
        out_ready = 1'b0;
    endtask

    // Beat is committed at the next posedge; sample mid-cycle.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL beat_unexpected: got data 0x%0h last %0b expected no beat at %0t",
                         out_data, out_last, $time);
            end else begin
                logic [W:0] e;
                e = exp_q.pop_front();
                if ({out_data, out_last} !== e) begin
                    n_fail++;
                    $display("FAIL beat: got data 0x%0h last %0b expected data 0x%0h last %0b at %0t",
                             out_data, out_last, e[W:1], e[0], $time);
                end
            end
        end
    end

    initial begin
        clear_inputs();
        rst   = 1'b1;
        grant = 4'b0010;

        // 1: reset holds everything idle despite a pending grant
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_owner", 32'(owner), 32'h0);
            check("rst_busy", 32'(busy), 32'h0);
            check("rst_out_valid", 32'(out_valid), 32'h0);
            check("rst_grant_err", 32'(grant_err), 32'h0);
        end
        grant = '0;
        rst   = 1'b0;
        tick();

        // 2: single burst ended by in_last
        grant = 4'b0100;
        tick();
        grant = '0;
        check("t2_owner", 32'(owner), 32'h4);
        check("t2_busy", 32'(busy), 32'h1);
        out_ready = 1'b1;
        drive(2, 8'hA1, 1'b0); exp_q.push_back({8'hA1, 1'b0}); tick();
        drive(2, 8'hA2, 1'b0); exp_q.push_back({8'hA2, 1'b0}); tick();
        drive(2, 8'hA3, 1'b1); exp_q.push_back({8'hA3, 1'b1}); tick();
        in_valid = '0; in_last = '0;
        #1;
        check("t2_release", 32'(burst_release), 32'h1);
        check("t2_rel_owner", 32'(owner), 32'h4);
        check("t2_rel_out_valid", 32'(out_valid), 32'h0);
        tick();
        check("t2_release_once", 32'(burst_release), 32'h0);
        check("t2_idle_owner", 32'(owner), 32'h0);
        check("t2_idle_busy", 32'(busy), 32'h0);
        clear_inputs();
        tick();

        // 3: beat-limit cut at 4 beats, remainder served on the next grant
        grant = 4'b0001;
        tick();
        grant = '0;
        check("t3_owner", 32'(owner), 32'h1);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(0, 8'(8'h30 + k), 1'b0);
            exp_q.push_back({8'(8'h30 + k), k == 3});
            tick();
        end
        drive(0, 8'h34, 1'b0);
        #1;
        check("t3_rel_in_ready", 32'(in_ready), 32'h0);
        check("t3_rel_out_valid", 32'(out_valid), 32'h0);
        check("t3_release", 32'(burst_release), 32'h1);
        tick();
        check("t3_idle_in_ready", 32'(in_ready), 32'h0);
        check("t3_idle_owner", 32'(owner), 32'h0);
        grant = 4'b0001;
        tick();
        grant = '0;
        check("t3_regrant_owner", 32'(owner), 32'h1);
        exp_q.push_back({8'h34, 1'b0}); tick();
        drive(0, 8'h35, 1'b1); exp_q.push_back({8'h35, 1'b1}); tick();
        in_valid = '0; in_last = '0;
        tick();
        clear_inputs();
        tick();

        // 4: backpressure on requester 1, grant moves to requester 0 mid-burst
        grant = 4'b0010;
        tick();
        grant = '0;
        check("t4_owner", 32'(owner), 32'h2);
        drive(0, 8'hC1, 1'b1);
        out_ready = 1'b1;
        drive(1, 8'hB1, 1'b0); exp_q.push_back({8'hB1, 1'b0}); tick();
        drive(1, 8'hB2, 1'b0); exp_q.push_back({8'hB2, 1'b0});
        out_ready = 1'b0;
        grant = 4'b0001;
        #1;
        check("t4_stall_in_ready", 32'(in_ready), 32'h0);
        check("t4_stall_out_valid", 32'(out_valid), 32'h1);
        tick();
        check("t4_stall_owner", 32'(owner), 32'h2);
        check("t4_stall_data", 32'(out_data), 32'hB2);
        tick();
        out_ready = 1'b1;
        #1;
        check("t4_in_ready_owner_only", 32'(in_ready), 32'h2);
        tick();
        drive(1, 8'hB3, 1'b1); exp_q.push_back({8'hB3, 1'b1}); tick();
        in_valid[1] = 1'b0; in_last[1] = 1'b0;
        #1;
        check("t4_rel_owner", 32'(owner), 32'h2);
        check("t4_release", 32'(burst_release), 32'h1);
        check("t4_rel_in_ready", 32'(in_ready), 32'h0);
        tick();
        check("t4_idle_owner", 32'(owner), 32'h0);
        exp_q.push_back({8'hC1, 1'b1});
        tick();
        grant = '0;
        check("t4_next_owner", 32'(owner), 32'h1);
        tick();
        tick();
        clear_inputs();
        tick();

        // 5: multi-hot grant picks lowest bit and sets the sticky error
        grant = 4'b0110;
        tick();
        grant = '0;
        check("t5_owner", 32'(owner), 32'h2);
        check("t5_grant_err", 32'(grant_err), 32'h1);
        out_ready = 1'b1;
        drive(1, 8'hD1, 1'b1); exp_q.push_back({8'hD1, 1'b1}); tick();
        in_valid = '0; in_last = '0;
        tick();
        tick();
        check("t5_err_sticky", 32'(grant_err), 32'h1);
        clear_inputs();

        // 6: reset after beat 2 of 4, then a fresh full-length burst
        grant = 4'b1000;
        tick();
        grant = '0;
        check("t6_owner", 32'(owner), 32'h8);
        out_ready = 1'b1;
        drive(3, 8'hE1, 1'b0); exp_q.push_back({8'hE1, 1'b0}); tick();
        drive(3, 8'hE2, 1'b0); exp_q.push_back({8'hE2, 1'b0}); tick();
        drive(3, 8'hE3, 1'b0);
        rst = 1'b1;
        #1;
        check("t6_rst_out_valid", 32'(out_valid), 32'h0);
        check("t6_rst_in_ready", 32'(in_ready), 32'h0);
        check("t6_rst_owner", 32'(owner), 32'h0);
        check("t6_rst_busy", 32'(busy), 32'h0);
        check("t6_rst_err_clear", 32'(grant_err), 32'h0);
        tick();
        clear_inputs();
        rst = 1'b0;
        tick();
        grant = 4'b1000;
        tick();
        grant = '0;
        check("t6_fresh_owner", 32'(owner), 32'h8);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(3, 8'(8'hF0 + k), 1'b0);
            exp_q.push_back({8'(8'hF0 + k), k == 3});
            tick();
        end
        in_valid = '0;
        #1;
        check("t6_fresh_release", 32'(burst_release), 32'h1);
        tick();
        clear_inputs();
        tick();

        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/grant_burst_ctrl.md
Name: grant_burst_ctrl

Overview:
- Downstream stage of the 4-requester fixed-priority arbiter.
- Consumes the arbiter's grant vector, locks ownership of a shared output channel to the granted requester, and routes that requester's data beats through a valid/ready handshake.
- Ownership lasts until a burst ends: on a last-flagged beat or after MAX_BURST beats.
- On burst end it emits a one-cycle release pulse so the arbiter's requester can drop or renew its request.

Parameters:
- N, 4, number of requesters; matches the arbiter's req/grant width.
- W, 8, data width per requester.
- MAX_BURST, 4, maximum beats per ownership; legal range 1..16.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- grant  input  N  one-hot grant from the fixed-priority arbiter; bit 0 is highest priority.
- in_valid  input  N  per-requester data valid.
- in_data  input  N*W  packed requester data; requester i occupies bits [i*W +: W].
- in_last  input  N  per-requester last-beat flag.
- in_ready  output  N  per-requester ready; only the owner's bit can be high.
- out_valid  output  1  shared channel valid.
- out_data  output  W  shared channel data.
- out_last  output  1  high on the beat that ends the burst, whether by in_last or by the beat limit.
- out_ready  input  1  shared channel ready.
- owner  output  N  registered one-hot owner; zero when idle.
- busy  output  1  high while in XFER or RELEASE.
- release  output  1  one-cycle pulse at burst end.
- grant_err  output  1  sticky flag: a multi-hot grant was sampled.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - state=IDLE, owner=0, beat count=0, release=0, grant_err=0.
  - Consequently out_valid=0, out_last=0, in_ready=0, busy=0.
- States: IDLE, XFER, RELEASE.
- IDLE:
  - grant is sampled every cycle.
  - If grant≠0: owner<=lowest set bit of grant, count<=0, go to XFER.
  - If grant has more than one bit set, grant_err<=1. grant_err is cleared only by rst.
  - If grant=0, stay in IDLE.
- Latency: grant seen at edge T makes owner valid after edge T; the first beat can transfer at edge T+1.
- XFER datapath (combinational from the owner register):
  - out_valid = in_valid[owner]
  - out_data = in_data slice of owner
  - in_ready[owner] = out_ready; all other in_ready bits are 0.
- Beat: out_valid && out_ready at a rising edge. Each beat increments count.
- Burst end: a beat where in_last[owner]=1 or count==MAX_BURST-1.
  - out_last is high combinationally on that beat.
  - At that edge, go to RELEASE.
- No beat: state and count hold. A stalled owner keeps the channel indefinitely; there is no timeout.
- grant is ignored in XFER and RELEASE. A grant change mid-burst does not change owner.
- RELEASE (exactly one cycle):
  - release=1, out_valid=0, in_ready=0, owner still shows the finishing requester.
  - Next state is IDLE with owner<=0. grant is sampled again in IDLE the following cycle, so back-to-back bursts have a 2-cycle gap (RELEASE + IDLE sample).
- Boundary conditions:
  - MAX_BURST=1: every beat ends the burst.
  - in_last and the beat limit on the same beat: a single end, single release.
  - Count width is clog2(MAX_BURST)+1. count never wraps because the burst ends at the limit.
- Reset mid-burst: immediate return to IDLE. Outputs are zero asynchronously, and any in-flight beat is dropped.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE=2'd0, XFER=2'd1, RELEASE=2'd2);
  - default N/W values;
  - the beat-count width function.
- One sub-module, onehot_lsb_pick: combinational lowest-set-bit isolate plus multi-hot detect. It is reusable by the arbiter family.
- The data mux stays inline.

Test Plan:
1. Reset: rst=1 for 20 ns with grant=4'b0010 -> owner=0, busy=0, out_valid=0, grant_err=0 throughout; no state change until rst=0.
2. Single burst by in_last:
   - Stimulus: grant=4'b0100; requester 2 drives 3 beats 8'hA1, A2, A3 with in_last on A3; out_ready=1.
   - Response: owner=4'b0100 one cycle after grant; out_data A1..A3 on consecutive cycles; out_last on A3; release pulse the next cycle; then owner=0.
3. Beat-limit cut (MAX_BURST=4):
   - Stimulus: requester 0 streams 6 beats with no in_last.
   - Response: exactly 4 beats pass; out_last on beat 4; in_ready[0]=0 from RELEASE on; remaining beats wait for the next grant.
4. Backpressure and grant change:
   - Stimulus: out_ready toggles 1,0,0,1 during requester 1's burst; grant switches to 4'b0001 mid-burst.
   - Response: no beat on the stall cycles; data held; owner stays 4'b0010 until release; requester 0 is served after IDLE.
5. Multi-hot grant: grant=4'b0110 in IDLE -> owner=4'b0010 and grant_err=1; grant_err stays 1 after the burst completes.
6. Reset mid-burst: rst=1 asserted after beat 2 of 4 -> out_valid, in_ready, owner and busy all 0 immediately; after deassert, the next grant starts a fresh burst with count=0.
